// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-channel round-robin arbiter with exclusive grant ownership.
// A requester keeps the grant until it raises its eot bit or drops its request;
// on release the next requester after the previous owner (rotating order) gets
// the grant on the same edge, so handoffs have no idle cycle.
// Optional feature macro: RRA_HOLD_TIMEOUT_EN. When defined, a hold counter
// forcibly reclaims a grant after MAX_HOLD cycles and pulses `timeout`.
// When undefined, `timeout` is tied low and grants are held indefinitely.
module rr_arbiter_n #(
    parameter int NCH      = 4,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH-1:0]         eot,
    output logic [NCH-1:0]         gnt,
    output logic [$clog2(NCH)-1:0] gnt_idx,
    output logic                   busy,
    output logic                   timeout
);
    localparam int IW = $clog2(NCH);

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

    state_t         state_reg;
    logic [NCH-1:0] gnt_reg;
    logic [IW-1:0]  gnt_idx_reg;
    logic [IW-1:0]  last_reg;
    logic           busy_reg;

    logic [NCH-1:0] own_onehot;
    logic [NCH-1:0] own_mask;
    logic [NCH-1:0] cand_req;
    logic [NCH-1:0] rot_req;
    logic [NCH-1:0] win_onehot;
    logic [IW-1:0]  rot_pos;
    logic [IW:0]    win_sum;
    logic [IW-1:0]  win_idx;
    logic           win_found;
    logic           owner_req;
    logic           owner_eot;
    logic           force_rel;
    logic           release_now;

    // One-hot decodes of the current owner and of the arbitration winner.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_dec
        assign own_onehot[gi] = (gnt_idx_reg == IW'(gi));
        assign win_onehot[gi] = (win_idx == IW'(gi));
    end

    // Only the owner's request/eot bits matter while a grant is held.
    assign owner_req = |(req & own_onehot);
    assign owner_eot = |(eot & own_onehot);

    // The owner competes only when nobody else asks, so mask it out of the search.
    assign own_mask = (state_reg == ST_GRANT) ? own_onehot : '0;
    assign cand_req = req & ~own_mask;

    // Rotate so bit 0 is channel last+1; a doubled vector gives the wrap for free.
    assign rot_req = NCH'({cand_req, cand_req} >> (int'(last_reg) + 1));

    // Lowest set bit of the rotated vector is the first requester in rotation order.
    always_comb begin
        win_found = |rot_req;
        rot_pos   = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (rot_req[j]) begin
                rot_pos = IW'(j);
            end
        end
    end

    // Map the rotated position back to an absolute channel index (modulo NCH).
    assign win_sum = {1'b0, last_reg} + (IW+1)'(1) + {1'b0, rot_pos};
    assign win_idx = (win_sum >= (IW+1)'(NCH)) ? IW'(win_sum - (IW+1)'(NCH))
                                               : win_sum[IW-1:0];

    assign release_now = owner_eot | ~owner_req | force_rel;

`ifdef RRA_HOLD_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD + 1);

    logic [HW-1:0] hold_cnt_reg;
    logic          timeout_reg;

    // Reaching MAX_HOLD-1 at an edge means the owner has held MAX_HOLD cycles.
    assign force_rel = (state_reg == ST_GRANT) && (hold_cnt_reg == HW'(MAX_HOLD - 1));

    // Hold counter restarts on every (re)grant; timeout flags a purely forced release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= force_rel & owner_req & ~owner_eot;
            if (state_reg != ST_GRANT || release_now) begin
                hold_cnt_reg <= '0;
            end else begin
                hold_cnt_reg <= hold_cnt_reg + HW'(1);
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign force_rel = 1'b0;
    assign timeout   = 1'b0;

    // MAX_HOLD only shapes the timeout path; out-of-range values show up as this scope.
    if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_max_hold_out_of_range
    end
`endif

    // Grant FSM: acquire from idle, hand off / re-grant / go idle on release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            gnt_reg     <= '0;
            gnt_idx_reg <= '0;
            last_reg    <= IW'(NCH - 1);
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_found) begin
                        state_reg   <= ST_GRANT;
                        gnt_reg     <= win_onehot;
                        gnt_idx_reg <= win_idx;
                        last_reg    <= win_idx;
                        busy_reg    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    if (release_now) begin
                        if (win_found) begin
                            gnt_reg     <= win_onehot;
                            gnt_idx_reg <= win_idx;
                            last_reg    <= win_idx;
                        end else if (!owner_req) begin
                            state_reg <= ST_IDLE;
                            gnt_reg   <= '0;
                            busy_reg  <= 1'b0;
                        end
                        // Otherwise the owner is re-granted: outputs stay as they are.
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign gnt     = gnt_reg;
    assign gnt_idx = gnt_idx_reg;
    assign busy    = busy_reg;
endmodule

// File: doc/rr_arbiter_n.md
# rr_arbiter_n

Parametrised round-robin arbiter granting one of `NCH` requesters exclusive ownership of a shared resource until the owner signals end-of-transaction (`eot`) or drops its request. It is the N-channel successor of the fixed 4-channel arbiter and sits between the requesting masters and the shared target. It adds:
- an encoded grant index;
- a busy flag;
- an optional hold-timeout that forcibly reclaims a stuck grant.

## Interface
Parameters:
- `NCH`, 4: number of requesters; legal range 2..32.
- `MAX_HOLD`, 16: maximum grant duration in cycles when the timeout is compiled in; legal range 1..65535.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `req`  in  NCH  request per channel; level, held until served.
- `eot`  in  NCH  end-of-transaction per channel; only the owner's bit is used.
- `gnt`  out  NCH  one-hot grant, registered; all-zero when idle.
- `gnt_idx`  out  $clog2(NCH)  encoded index of the owner; holds the last owner when idle.
- `busy`  out  1  high while any grant is active (equals `|gnt`).
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- State machine with two states:
  - IDLE: no owner.
  - GRANT: one owner, held in `gnt_idx`.
- Rotating pointer `last` holds the index of the previous owner.
  - Search order is `last+1, last+2, …` modulo NCH, wrapping from NCH-1 to 0.
  - The first channel in that order with `req` high wins.
- IDLE → GRANT: on any edge with `|req`. The winner is granted and `last` is set to the winner.
- In GRANT, the release condition is any one of:
  - `eot[gnt_idx]` is high;
  - `req[gnt_idx]` is low;
  - timeout expiry (see Configuration).
- On release, arbitration runs on the same edge using the current `req` with the owner's bit masked:
  - Another requester wins: direct handoff to it. State stays GRANT and there is no idle cycle.
  - No other requester, but the owner still requests and released via `eot` or timeout: the owner is re-granted.
  - Nobody requests: → IDLE, `gnt`=0, `busy`=0.
- While in GRANT without a release condition:
  - `req` changes on non-owner channels have no effect.
  - `eot` on non-owner channels is ignored.
- `gnt` is always one-hot or zero; two bits are never high at once.

## Timing
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `busy`=0, `timeout`=0.
  - State is IDLE.
  - `last`=NCH-1, so channel 0 has first priority after reset.
  - Hold counter = 0.
- Grant latency: a `req` sampled high at edge k in IDLE gives `gnt` high after edge k (one cycle from request setup).
- Handoff: release sampled at edge k → the new `gnt` is valid after edge k. The old owner's bit falls on the same edge.
- `eot` and `req` are sampled only at rising edges; glitches between edges are ignored.
- Reset asserted mid-grant clears all outputs immediately (asynchronously) and returns `last` to NCH-1. After deassertion, the first arbitration occurs on the first edge with `|req`.
- `busy` and `gnt_idx` are registered together with `gnt` and change on the same edge.

## Configuration
- Macro `RRA_HOLD_TIMEOUT_EN` defined:
  - A hold counter of width $clog2(MAX_HOLD+1) clears on every grant or re-grant and increments each cycle in GRANT.
  - When the counter equals MAX_HOLD-1 and no other release condition is present, release is forced on that edge, so the owner holds for exactly MAX_HOLD cycles.
  - `timeout` pulses high for the one cycle following the forced release.
  - An `eot` arriving on the same edge takes precedence: no timeout pulse.
- Macro not defined:
  - No counter is present and `timeout` is tied 0.
  - A grant is held indefinitely until `eot` or the owner's request drops.

## Test plan
- Reset check: assert `rst` with `req`=4'b1111 → `gnt`=0, `busy`=0, `gnt_idx`=0. After release, first grant is `gnt`=4'b0001.
- Rotation: NCH=4, all `req` held high, pulse `eot` of each owner in turn → grant order 0,1,2,3,0 with back-to-back handoff and `busy` never dropping.
- Sole requester: only `req[2]` high, pulse `eot[2]` → `gnt` stays 4'b0100 (re-grant), `gnt_idx`=2. Drop `req[2]` → `gnt`=0 on the next edge.
- Ignored signals: owner=1, pulse `eot[3]` and toggle `req[0]` → `gnt` unchanged at 4'b0010.
- Timeout (macro defined, MAX_HOLD=4): `req[1]` and `req[3]` high with no `eot` → ch1 is held exactly 4 cycles, `timeout` pulses once, `gnt` moves to 4'b1000.
- Wrap and async reset: NCH=8, owner=7 releases with `req[7]` and `req[0]` high → `gnt`=8'h01. Then assert `rst` mid-grant between edges → `gnt`=0 immediately.
